floor_request_tracker: RTL and testbench

- Elevator datapath stage directly upstream of the main control FSM.
- Latches hall and cabin floor requests and tracks the cab position as a one-hot floor vector, advancing it from the FSM's up/down commands after a fixed travel time.
- Produces the request_i / request_j_gt_i / request_j_lt_i status flags that the control FSM consumes.

---
 rtl/floor_request_tracker.sv | 107 ++++++++++
 tb/tb_floor_request_tracker.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/floor_request_tracker.sv
// Latches hall/cabin requests, tracks the one-hot cab position and derives the control FSM's request flags.
// Flags are combinational from registered state; one floor step per TRAVEL cycles; no backpressure.
module floor_request_tracker #(
  parameter int N      = 10,
  parameter int TRAVEL = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] button_out,
  input  logic [N-1:0] button_in,
  input  logic         open,
  input  logic         up,
  input  logic         down,
  output logic [N-1:0] current_floor,
  output logic         request_i,
  output logic         request_j_gt_i,
  output logic         request_j_lt_i,
  output logic [N-1:0] pending,
  output logic         arrive,
  output logic         move_err
);

  localparam int TW = $clog2(TRAVEL) + 1;
  localparam logic [TW-1:0] TLAST = TW'(TRAVEL - 1);
  localparam logic [N-1:0]  ONE   = N'(1);

  typedef enum logic [1:0] {IDLE, MOVING_UP, MOVING_DOWN} state_t;

  state_t        state, state_nx;
  logic [TW-1:0] tcnt, tcnt_nx;
  logic [N-1:0]  floor_nx, pend_nx, above_mask, below_mask;
  logic          arrive_nx, err_nx;
  logic          at_top, at_bot, go_up, go_dn, step_up, step_dn, cnt_done;

  assign at_top = current_floor[N-1];
  assign at_bot = current_floor[0];
  assign go_up  = up & ~down & ~open;
  assign go_dn  = down & ~up & ~open;

  // A move may start from IDLE or continue in the same direction; anything else aborts.
  assign step_up  = (state == IDLE || state == MOVING_UP) && go_up && !at_top;
  assign step_dn  = (state == IDLE || state == MOVING_DOWN) && go_dn && !at_bot;
  assign cnt_done = (tcnt == TLAST);

  assign err_nx = (up & at_top) | (down & at_bot) | (up & down) | ((up | down) & open);

  // Door-open clear at the current floor takes priority over a new press there.
  assign pend_nx = (pending | button_out | button_in) & ~(open ? current_floor : '0);

  always_comb begin
    state_nx  = state;
    tcnt_nx   = tcnt;
    floor_nx  = current_floor;
    arrive_nx = 1'b0;
    if (step_up) begin
      if (cnt_done) begin
        floor_nx  = current_floor << 1;
        tcnt_nx   = '0;
        arrive_nx = 1'b1;
        state_nx  = current_floor[N-2] ? IDLE : MOVING_UP;
      end else begin
        tcnt_nx  = tcnt + TW'(1);
        state_nx = MOVING_UP;
      end
    end else if (step_dn) begin
      if (cnt_done) begin
        floor_nx  = current_floor >> 1;
        tcnt_nx   = '0;
        arrive_nx = 1'b1;
        state_nx  = current_floor[1] ? IDLE : MOVING_DOWN;
      end else begin
        tcnt_nx  = tcnt + TW'(1);
        state_nx = MOVING_DOWN;
      end
    end else begin
      state_nx = IDLE;
      tcnt_nx  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      tcnt          <= '0;
      current_floor <= ONE;
      pending       <= '0;
      arrive        <= 1'b0;
      move_err      <= 1'b0;
    end else begin
      state         <= state_nx;
      tcnt          <= tcnt_nx;
      current_floor <= floor_nx;
      pending       <= pend_nx;
      arrive        <= arrive_nx;
      move_err      <= err_nx;
    end
  end

  // At the top floor the shift wraps to zero, so the above-mask correctly becomes empty.
  assign above_mask = ~((current_floor << 1) - ONE);
  assign below_mask = current_floor - ONE;

  assign request_i      = |(pending & current_floor);
  assign request_j_gt_i = |(pending & above_mask);
  assign request_j_lt_i = |(pending & below_mask);

endmodule

// File: tb/tb_floor_request_tracker.sv
// Directed bench for floor_request_tracker; stimulus queues expected snapshots, a monitor compares them.
// Direct in-line checks back up the monitor at key points (press latch, arrival, async reset).
// Stimulus driven 1 time unit after the clock edge; no backpressure.
module tb_floor_request_tracker;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] button_out, button_in;
    logic       open, up, down;
    logic [9:0] current_floor, pending;
    logic       request_i, request_j_gt_i, request_j_lt_i, arrive, move_err;

    floor_request_tracker #(.N(10), .TRAVEL(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .button_out     (button_out),
        .button_in      (button_in),
        .open           (open),
        .up             (up),
        .down           (down),
        .current_floor  (current_floor),
        .request_i      (request_i),
        .request_j_gt_i (request_j_gt_i),
        .request_j_lt_i (request_j_lt_i),
        .pending        (pending),
        .arrive         (arrive),
        .move_err       (move_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [9:0] cf;
        logic [9:0] pend;
        logic       ri, gt, lt, arr, err;
    } obs_t;

    typedef struct {
        int    cyc;
        string name;
        obs_t  o;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic async_chk = 1'b0;
    exp_t mon_e;
    obs_t mon_a;

    always @(posedge clk) cyc <= cyc + 1;

    always begin
        @(negedge clk or posedge async_chk);
        while (sb.size() > 0 && sb[0].cyc == cyc) begin
            mon_e = sb.pop_front();
            mon_a = {current_floor, pending, request_i, request_j_gt_i, request_j_lt_i, arrive, move_err};
            checks++;
            if (mon_a !== mon_e.o) begin
                errors++;
                $display("FAIL %s: got cf=%h pend=%h ri=%b gt=%b lt=%b arr=%b err=%b, want cf=%h pend=%h ri=%b gt=%b lt=%b arr=%b err=%b",
                         mon_e.name, mon_a.cf, mon_a.pend, mon_a.ri, mon_a.gt, mon_a.lt, mon_a.arr, mon_a.err,
                         mon_e.o.cf, mon_e.o.pend, mon_e.o.ri, mon_e.o.gt, mon_e.o.lt, mon_e.o.arr, mon_e.o.err);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic exp_now(input string nm, input logic [9:0] cf, input logic [9:0] pend,
                           input logic ri, input logic gt, input logic lt,
                           input logic arr, input logic err);
        exp_t e;
        e.cyc  = cyc;
        e.name = nm;
        e.o    = {cf, pend, ri, gt, lt, arr, err};
        sb.push_back(e);
    endtask

    initial begin
        rst = 1'b1; button_out = '0; button_in = '0; open = 1'b0; up = 1'b0; down = 1'b0;
        step(2);
        exp_now("reset_state", 10'h001, 10'h000, 0, 0, 0, 0, 0);
        rst = 1'b0;
        step(3);
        exp_now("idle_after_reset", 10'h001, 10'h000, 0, 0, 0, 0, 0);

        button_in = 10'h020;
        step(1);
        button_in = '0;
        exp_now("press_in5", 10'h001, 10'h020, 0, 1, 0, 0, 0);
        checks++;
        if (pending !== 10'h020 || request_j_gt_i !== 1'b1 || request_i !== 1'b0 || request_j_lt_i !== 1'b0) begin
            errors++;
            $display("FAIL direct_press_in5: pend=%h ri=%b gt=%b lt=%b", pending, request_i, request_j_gt_i, request_j_lt_i);
        end

        up = 1'b1;
        step(8);
        exp_now("up_arrive1", 10'h002, 10'h020, 0, 1, 0, 1, 0);
        step(1);
        exp_now("up_between", 10'h002, 10'h020, 0, 1, 0, 0, 0);
        step(7);
        exp_now("up_arrive2", 10'h004, 10'h020, 0, 1, 0, 1, 0);
        checks++;
        if (current_floor !== 10'h004 || arrive !== 1'b1) begin
            errors++;
            $display("FAIL direct_up_arrive2: cf=%h arr=%b", current_floor, arrive);
        end
        up = 1'b0;
        step(1);
        exp_now("up_released", 10'h004, 10'h020, 0, 1, 0, 0, 0);

        up = 1'b1;
        step(24);
        exp_now("arrive_floor5", 10'h020, 10'h020, 1, 0, 0, 1, 0);
        up = 1'b0;
        step(1);
        exp_now("idle_floor5", 10'h020, 10'h020, 1, 0, 0, 0, 0);

        open = 1'b1; button_out = 10'h020; button_in = 10'h002;
        step(1);
        exp_now("open_clear", 10'h020, 10'h002, 0, 0, 1, 0, 0);
        checks++;
        if (pending[5] !== 1'b0 || request_i !== 1'b0) begin
            errors++;
            $display("FAIL direct_open_clear: pend=%h ri=%b", pending, request_i);
        end
        button_out = '0; button_in = '0; up = 1'b1;
        step(1);
        exp_now("up_with_open_err", 10'h020, 10'h002, 0, 0, 1, 0, 1);
        up = 1'b0; open = 1'b0;
        step(1);
        exp_now("err_one_cycle", 10'h020, 10'h002, 0, 0, 1, 0, 0);

        up = 1'b1;
        step(5);
        exp_now("partial_hold", 10'h020, 10'h002, 0, 0, 1, 0, 0);
        up = 1'b0;
        step(1);
        exp_now("partial_abort", 10'h020, 10'h002, 0, 0, 1, 0, 0);
        up = 1'b1;
        step(7);
        exp_now("second_hold_7", 10'h020, 10'h002, 0, 0, 1, 0, 0);
        step(1);
        exp_now("second_hold_8", 10'h040, 10'h002, 0, 0, 1, 1, 0);
        up = 1'b0;
        step(1);
        exp_now("after_second_hold", 10'h040, 10'h002, 0, 0, 1, 0, 0);

        up = 1'b1; down = 1'b1;
        step(1);
        exp_now("up_down_err", 10'h040, 10'h002, 0, 0, 1, 0, 1);
        up = 1'b0; down = 1'b0;
        step(1);
        exp_now("up_down_clear", 10'h040, 10'h002, 0, 0, 1, 0, 0);

        down = 1'b1;
        step(48);
        exp_now("arrive_floor0", 10'h001, 10'h002, 0, 1, 0, 1, 0);
        step(1);
        exp_now("down_at_bottom_err", 10'h001, 10'h002, 0, 1, 0, 0, 1);
        down = 1'b0;
        step(1);
        exp_now("bottom_err_clear", 10'h001, 10'h002, 0, 1, 0, 0, 0);

        up = 1'b1;
        step(24);
        exp_now("arrive_floor3", 10'h008, 10'h002, 0, 0, 1, 1, 0);
        step(3);
        #1 rst = 1'b1;
        exp_now("async_reset", 10'h001, 10'h000, 0, 0, 0, 0, 0);
        #1 async_chk = 1'b1;
        checks++;
        if (current_floor !== 10'h001 || pending !== 10'h000 || arrive !== 1'b0 || move_err !== 1'b0) begin
            errors++;
            $display("FAIL direct_async_reset: cf=%h pend=%h arr=%b err=%b", current_floor, pending, arrive, move_err);
        end
        #1 async_chk = 1'b0;
        up = 1'b0;
        step(1);
        exp_now("reset_held", 10'h001, 10'h000, 0, 0, 0, 0, 0);
        rst = 1'b0;
        step(2);
        exp_now("after_reset_idle", 10'h001, 10'h000, 0, 0, 0, 0, 0);
        checks++;
        if (current_floor !== 10'h001 || request_i !== 1'b0 || request_j_gt_i !== 1'b0 || request_j_lt_i !== 1'b0) begin
            errors++;
            $display("FAIL direct_after_reset: cf=%h ri=%b gt=%b lt=%b", current_floor, request_i, request_j_gt_i, request_j_lt_i);
        end

        for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
        #1;
        while (sb.size() > 0) begin
            mon_e = sb.pop_front();
            checks++;
            errors++;
            $display("FAIL %s: got no sample, want a snapshot at cycle %0d", mon_e.name, mon_e.cyc);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
